// File: rtl/ram_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : ram_ctrl_pkg
// Description : Shared opcodes, FSM states and defaults for the RAM arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ram_ctrl_pkg;

  localparam int ADDR_SIZE_DEFAULT = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD0 = 3'd1,
    ST_CMD1 = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
//------------------------------------------------------------------------------
// Module      : rr_arbiter2
// Description : Two-way round-robin grant; last winner loses the next tie.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic grant_valid,
  output logic grant_id
);

  logic r_last_grant;

  always_comb begin
    grant_valid = valid0 | valid1;
    if (valid0 && valid1) grant_id = ~r_last_grant;
    else                  grant_id = valid1;
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_last_grant <= 1'b1;
    else if (accept) r_last_grant <= grant_id;
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter_ctrl.sv
//------------------------------------------------------------------------------
// Module      : ram_arbiter_ctrl
// Description : Arbitrates two requesters onto the RAM command port and
//               sequences two-word read/write commands with read timeout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_arbiter_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT,
  parameter int TIMEOUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r0_req_valid,
  input  logic                 r0_req_we,
  input  logic [ADDR_SIZE-1:0] r0_req_addr,
  input  logic [ADDR_SIZE-1:0] r0_req_wdata,
  output logic                 r0_req_ready,
  output logic                 r0_rsp_valid,
  input  logic                 r1_req_valid,
  input  logic                 r1_req_we,
  input  logic [ADDR_SIZE-1:0] r1_req_addr,
  input  logic [ADDR_SIZE-1:0] r1_req_wdata,
  output logic                 r1_req_ready,
  output logic                 r1_rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t               r_state, w_next_state;
  logic                 w_grant_valid, w_grant_id, w_accept;
  logic                 r_id, r_we;
  logic [ADDR_SIZE-1:0] r_addr, r_wdata;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic [ADDR_SIZE+1:0] w_din;
  logic                 w_rx_valid, w_rsp0, w_rsp1, w_err;
  logic [ADDR_SIZE-1:0] w_rdata;
  logic                 w_sel_we;
  logic [ADDR_SIZE-1:0] w_sel_addr;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .valid0      (r0_req_valid),
    .valid1      (r1_req_valid),
    .accept      (w_accept),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  assign w_accept     = (r_state == ST_IDLE) && w_grant_valid;
  assign r0_req_ready = w_accept && !w_grant_id;
  assign r1_req_ready = w_accept &&  w_grant_id;
  assign w_sel_we     = w_grant_id ? r1_req_we   : r0_req_we;
  assign w_sel_addr   = w_grant_id ? r1_req_addr : r0_req_addr;

  // State and registered outputs; outputs are loaded with the values for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_cnt;
      ram_din      <= w_din;
      ram_rx_valid <= w_rx_valid;
      r0_rsp_valid <= w_rsp0;
      r1_rsp_valid <= w_rsp1;
      rsp_rdata    <= w_rdata;
      rsp_err      <= w_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_id    <= w_grant_id;
      r_we    <= w_sel_we;
      r_addr  <= w_sel_addr;
      r_wdata <= w_grant_id ? r1_req_wdata : r0_req_wdata;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_CMD0;
      ST_CMD0: w_next_state = ST_CMD1;
      ST_CMD1: w_next_state = r_we ? ST_RESP : ST_WAIT;
      ST_WAIT: if (ram_tx_valid || (r_cnt == CNT_W'(TIMEOUT - 1))) w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_din      = '0;
    w_rx_valid = 1'b0;
    w_rsp0     = 1'b0;
    w_rsp1     = 1'b0;
    w_rdata    = rsp_rdata;
    w_err      = rsp_err;
    w_cnt      = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_rx_valid = 1'b1;
          w_din      = {(w_sel_we ? OP_WR_ADDR : OP_RD_ADDR), w_sel_addr};
        end
      end
      ST_CMD0: begin
        w_rx_valid = 1'b1;
        w_din      = {(r_we ? OP_WR_DATA : OP_RD_DATA), (r_we ? r_wdata : '0)};
      end
      ST_CMD1: begin
        w_cnt = '0;
        if (r_we) begin
          w_rsp0  = !r_id;
          w_rsp1  =  r_id;
          w_rdata = '0;
          w_err   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (ram_tx_valid) begin
          w_rsp0  = !r_id;
          w_rsp1  =  r_id;
          w_rdata = ram_dout;
          w_err   = 1'b0;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_rsp0  = !r_id;
          w_rsp1  =  r_id;
          w_rdata = '0;
          w_err   = 1'b1;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_ram_arbiter_ctrl
// Description : Directed, table-driven bench for ram_arbiter_ctrl with a RAM model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_req_valid, r0_req_we, r0_req_ready, r0_rsp_valid;
  logic [7:0] r0_req_addr, r0_req_wdata;
  logic       r1_req_valid, r1_req_we, r1_req_ready, r1_rsp_valid;
  logic [7:0] r1_req_addr, r1_req_wdata;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter_ctrl #(.ADDR_SIZE(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_req_valid), .r0_req_we(r0_req_we), .r0_req_addr(r0_req_addr),
    .r0_req_wdata(r0_req_wdata), .r0_req_ready(r0_req_ready), .r0_rsp_valid(r0_rsp_valid),
    .r1_req_valid(r1_req_valid), .r1_req_we(r1_req_we), .r1_req_addr(r1_req_addr),
    .r1_req_wdata(r1_req_wdata), .r1_req_ready(r1_req_ready), .r1_rsp_valid(r1_rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  // RAM model: answers a read-data command one cycle later unless ram_en is low.
  logic [7:0] mem [256];
  logic [7:0] wa = 8'h00, ra = 8'h00, m_dout = 8'h00;
  logic       m_tx = 1'b0;
  logic       ram_en = 1'b1;
  logic       spur_tx = 1'b0;

  always @(posedge clk) begin
    m_tx <= 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: wa <= ram_din[7:0];
        2'b01: mem[wa] <= ram_din[7:0];
        2'b10: ra <= ram_din[7:0];
        2'b11: if (ram_en) begin m_tx <= 1'b1; m_dout <= mem[ra]; end
      endcase
    end
  end

  assign ram_tx_valid = m_tx | spur_tx;
  assign ram_dout     = spur_tx ? 8'hC3 : m_dout;

  typedef struct {
    logic       id;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       noresp;
    logic       spur;
    logic [9:0] cmd0;
    logic [9:0] cmd1;
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic id, input logic v, input logic we,
                           input logic [7:0] addr, input logic [7:0] wdata);
    if (!id) begin
      r0_req_valid = v; r0_req_we = we; r0_req_addr = addr; r0_req_wdata = wdata;
    end else begin
      r1_req_valid = v; r1_req_we = we; r1_req_addr = addr; r1_req_wdata = wdata;
    end
  endtask

  // Present a request, wait for its handshake; returns at edge T + 1ns.
  task automatic handshake(input logic id, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata, output bit ok);
    ok = 1'b0;
    drive_req(id, 1'b1, we, addr, wdata);
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk);
      if ((id ? r1_req_ready : r0_req_ready) === 1'b1) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("handshake", ok, 1'b1);
    if (ok) begin
      chk("ready_other", id ? r0_req_ready : r1_req_ready, 1'b0);
      @(posedge clk); #1;
    end
    // Inputs change after handshake; the DUT must already hold its copy.
    drive_req(id, 1'b0, ~we, ~addr, ~wdata);
  endtask

  task automatic run_txn(input vec_t v);
    bit ok;
    ram_en = !v.noresp;
    handshake(v.id, v.we, v.addr, v.wdata, ok);
    if (!ok) return;
    spur_tx = v.spur;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("ram_rx_valid", ram_rx_valid, (k == 1 || k == 2));
      chk("ram_din", ram_din, (k == 1) ? v.cmd0 : (k == 2) ? v.cmd1 : 10'h000);
      chk("rsp_valid_own", v.id ? r1_rsp_valid : r0_rsp_valid, (k == v.lat));
      chk("rsp_valid_other", v.id ? r0_rsp_valid : r1_rsp_valid, 1'b0);
      if (k == v.lat) begin
        chk("rsp_rdata", rsp_rdata, v.rdata);
        chk("rsp_err", rsp_err, v.err);
      end
      @(posedge clk); #1;
    end
    spur_tx = 1'b0;
    ram_en  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int  gid [4];
    int  rid [4];
    int  ng, nr;
    bit  ok;

    //            id  we  addr   wdata  nore spur cmd0    cmd1    rdata  err lat
    tbl[0] = '{1'b0, 1'b1, 8'h3C, 8'hA5, 1'b0, 1'b0, 10'h03C, 10'h1A5, 8'h00, 1'b0, 3};
    tbl[1] = '{1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 10'h23C, 10'h300, 8'hA5, 1'b0, 4};
    tbl[2] = '{1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0, 10'h000, 10'h111, 8'h00, 1'b0, 3};
    tbl[3] = '{1'b1, 1'b1, 8'hFF, 8'hEE, 1'b0, 1'b1, 10'h0FF, 10'h1EE, 8'h00, 1'b0, 3};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 10'h200, 10'h300, 8'h11, 1'b0, 4};
    tbl[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 10'h2FF, 10'h300, 8'hEE, 1'b0, 4};
    tbl[6] = '{1'b0, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b0, 10'h23C, 10'h300, 8'h00, 1'b1, 7};
    tbl[7] = '{1'b1, 1'b1, 8'h55, 8'h5A, 1'b0, 1'b1, 10'h055, 10'h15A, 8'h00, 1'b0, 3};
    tbl[8] = '{1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 10'h23C, 10'h300, 8'hA5, 1'b0, 4};

    rst = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    #12;
    chk("reset_rx_valid", ram_rx_valid, 1'b0);
    chk("reset_din", ram_din, 10'h000);
    chk("reset_rsp0", r0_rsp_valid, 1'b0);
    chk("reset_rsp1", r1_rsp_valid, 1'b0);
    chk("reset_rdata", rsp_rdata, 8'h00);
    chk("reset_err", rsp_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Both requesters held valid from reset: grants must alternate starting with r0.
    for (int i = 0; i < 4; i++) begin gid[i] = 9; rid[i] = 9; end
    ng = 0; nr = 0;
    drive_req(1'b0, 1'b1, 1'b1, 8'h10, 8'h01);
    drive_req(1'b1, 1'b1, 1'b1, 8'h20, 8'h02);
    for (int c = 0; c < 80 && nr < 4; c++) begin
      @(negedge clk);
      chk("both_ready", r0_req_ready & r1_req_ready, 1'b0);
      chk("both_rsp", r0_rsp_valid & r1_rsp_valid, 1'b0);
      if ((r0_req_ready | r1_req_ready) && ng < 4) begin gid[ng] = int'(r1_req_ready); ng++; end
      if ((r0_rsp_valid | r1_rsp_valid) && nr < 4) begin rid[nr] = int'(r1_rsp_valid); nr++; end
      @(posedge clk); #1;
      if (ng == 4) begin r0_req_valid = 1'b0; r1_req_valid = 1'b0; end
    end
    chk("grant_count", ng, 4);
    chk("rsp_count", nr, 4);
    for (int i = 0; i < 4; i++) begin
      chk("grant_order", gid[i], i % 2);
      chk("rsp_order", rid[i], i % 2);
    end
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // Spurious tx_valid in IDLE must not produce a response or touch rsp_rdata.
    spur_tx = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("spur_idle_rsp", r0_rsp_valid | r1_rsp_valid, 1'b0);
      chk("spur_idle_rdata", rsp_rdata, 8'hA5);
      @(posedge clk); #1;
    end
    spur_tx = 1'b0;

    // Reset while waiting on a silent RAM.
    ram_en = 1'b0;
    handshake(1'b0, 1'b0, 8'h77, 8'h00, ok);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rstwait_rx_valid", ram_rx_valid, 1'b0);
    chk("rstwait_din", ram_din, 10'h000);
    chk("rstwait_rsp", r0_rsp_valid | r1_rsp_valid, 1'b0);
    chk("rstwait_rdata", rsp_rdata, 8'h00);
    chk("rstwait_err", rsp_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    ram_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_rsp", r0_rsp_valid | r1_rsp_valid, 1'b0);
      chk("post_rst_rx", ram_rx_valid, 1'b0);
      @(posedge clk); #1;
    end
    run_txn(tbl[8]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
